// File: rtl/home_pkg.sv
// ---------------------------------------------------------------------------
// home_pkg
//   Shared definitions for the smart-home status reporter:
//     - display code values produced by the controller FSM
//     - bytes used to build the 2-byte status frame
//     - state encoding of the byte-level UART transmitter FSM
//     - code_to_byte(): maps a display code onto the ASCII payload byte
// ---------------------------------------------------------------------------
package home_pkg;

    // Display codes from the controller FSM
    localparam logic [2:0] DISP_IDLE   = 3'b000;
    localparam logic [2:0] DISP_FRONT  = 3'b001;
    localparam logic [2:0] DISP_REAR   = 3'b010;
    localparam logic [2:0] DISP_FIRE   = 3'b011;
    localparam logic [2:0] DISP_WINDOW = 3'b100;
    localparam logic [2:0] DISP_HEATER = 3'b101;
    localparam logic [2:0] DISP_COOLER = 3'b110;
    localparam logic [2:0] DISP_BAD    = 3'b111;

    // Frame bytes
    localparam logic [7:0] HDR_BYTE   = 8'h53;  // 'S'
    localparam logic [7:0] ASCII_ZERO = 8'h30;  // '0'
    localparam logic [7:0] BAD_BYTE   = 8'h3F;  // '?'

    // Byte transmitter FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Legal codes become '0'..'6'; the illegal code is reported as '?'.
    function automatic logic [7:0] code_to_byte(input logic [2:0] code);
        if (code == DISP_BAD) begin
            return BAD_BYTE;
        end
        return ASCII_ZERO + {5'b00000, code};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
//   Sends one 8N1 byte (start 0, 8 data bits LSB first, stop 1), each bit
//   lasting exactly CLKS_PER_BIT clock cycles.
//
//   Handshake: start is sampled while the FSM is IDLE, or in the last cycle
//   of a stop bit (the cycle where done=1). When accepted, data is loaded and
//   the start bit goes onto the line at that same edge, so a byte requested
//   while done=1 follows the previous stop bit with no idle gap. start is
//   ignored at all other times.
//
// Ports
//   clk        in   system clock, rising edge
//   Rst        in   synchronous active-high reset; line returns to idle (1)
//   start      in   request to send data (see handshake above)
//   data[7:0]  in   byte to send, sampled when start is accepted
//   txd        out  serial line, idle high
//   done       out  1 in the final cycle of the stop bit
//   dbg_state  out  current FSM state (tx_state_t encoding)
// ---------------------------------------------------------------------------
module uart_tx_byte
    import home_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done,
    output logic [1:0] dbg_state
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic             r_txd;

    tx_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shreg_nxt;
    logic             w_txd_nxt;
    logic             w_bit_end;

    // The counter reloads at every bit boundary, so each bit is exactly
    // CLKS_PER_BIT cycles long and no error accumulates across the byte.
    assign w_bit_end = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shreg   <= w_shreg_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_bit_end ? '0 : r_cnt + CNT_ONE;
        w_bit_nxt   = r_bit_idx;
        w_shreg_nxt = r_shreg;
        w_txd_nxt   = r_txd;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (start) begin
                    w_state_nxt = START;
                    w_shreg_nxt = data;
                    w_bit_nxt   = '0;
                    w_txd_nxt   = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_txd_nxt   = r_shreg[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        // shift right; the next bit to send is shreg[1]
                        w_bit_nxt   = r_bit_idx + 3'd1;
                        w_shreg_nxt = {1'b0, r_shreg[7:1]};
                        w_txd_nxt   = r_shreg[1];
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (start) begin
                        // back-to-back byte: start bit replaces the idle gap
                        w_state_nxt = START;
                        w_shreg_nxt = data;
                        w_bit_nxt   = '0;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_txd_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    assign txd       = r_txd;
    assign done      = (r_state == STOP) && w_bit_end;
    assign dbg_state = r_state;

endmodule

// File: rtl/home_status_uart_tx.sv
// ---------------------------------------------------------------------------
// home_status_uart_tx
//   Reports the controller's 3-bit display code to the wall panel as a
//   2-byte 8N1 frame: 'S' followed by '0'..'6' (or '?' for code 111).
//   A frame is sent once after reset and again whenever the registered
//   display code differs from the code of the most recently started frame.
//   Changes seen while a frame is on the line are coalesced: only the code
//   present when the line goes idle is reported.
//
// Ports
//   clk            in   system clock, rising edge
//   Rst            in   synchronous active-high reset; aborts any frame
//   display[2:0]   in   status code from the controller FSM
//   tx_en          in   1 = a new frame may start; an in-flight frame
//                       always completes regardless
//   txd            out  UART line, idle high, LSB first
//   busy           out  1 while a frame is on the line
//   frame_cnt[7:0] out  frames completed since reset (wraps)
// ---------------------------------------------------------------------------
module home_status_uart_tx
    import home_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic [2:0] display,
    input  logic       tx_en,
    output logic       txd,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    logic [2:0] r_disp_q;
    logic [2:0] r_last_code;
    logic [2:0] r_frame_code;
    logic       r_boot_pend;
    logic       r_busy;
    logic       r_byte_sel;     // 0 = header byte on the line, 1 = code byte
    logic [7:0] r_frame_cnt;

    logic       w_launch;
    logic       w_next_byte;
    logic       w_start;
    logic [7:0] w_data;
    logic       w_done;
    logic       w_txd;
    logic [1:0] w_tx_state;

    // Input register only; it carries no reset so it keeps tracking the
    // display while Rst is high and the boot frame reports the current code.
    always_ff @(posedge clk) begin
        r_disp_q <= display;
    end

    // A new frame starts only from an idle line.
    assign w_launch    = (w_tx_state == IDLE) && tx_en &&
                         (r_boot_pend || (r_disp_q != r_last_code));
    // Second byte is requested during the header's final stop cycle so it
    // follows without a gap.
    assign w_next_byte = w_done && !r_byte_sel;
    assign w_start     = w_launch || w_next_byte;
    assign w_data      = w_launch ? HDR_BYTE : code_to_byte(r_frame_code);

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_last_code  <= DISP_IDLE;
            r_frame_code <= DISP_IDLE;
            r_boot_pend  <= 1'b1;
            r_busy       <= 1'b0;
            r_byte_sel   <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else if (w_launch) begin
            r_last_code  <= r_disp_q;
            r_frame_code <= r_disp_q;
            r_boot_pend  <= 1'b0;
            r_busy       <= 1'b1;
            r_byte_sel   <= 1'b0;
        end else if (w_done) begin
            if (!r_byte_sel) begin
                r_byte_sel <= 1'b1;
            end else begin
                r_busy      <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk       (clk),
        .Rst       (Rst),
        .start     (w_start),
        .data      (w_data),
        .txd       (w_txd),
        .done      (w_done),
        .dbg_state (w_tx_state)
    );

    assign txd       = w_txd;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;

endmodule
